tmr_state_scrubber: RTL

- Triple-modular-redundant (TMR) state register for the satellite mode FSM.
- Holds three copies of the FSM state and presents a bitwise majority-voted value.
- Detects a single corrupted copy and rewrites it from the vote (scrub), counts upsets, and raises a sticky fail flag on persistent uncorrectable disagreement.
- Sits between the FSM next-state logic and all state consumers; it is the read/repair side of the state-write path.

---
 rtl/tmr_state_scrubber_if.sv | 27 ++
 rtl/tmr_state_scrubber.sv | 132 +++++++++++++
 2 files changed

// File: rtl/tmr_state_scrubber_if.sv
// Bus between the mode-FSM next-state logic and the TMR state scrubber.
// The master drives the state write and SEU injection; the slave returns the vote and status.
interface tmr_state_scrubber_if #(
    parameter int STATE_W   = 3,
    parameter int ERR_CNT_W = 8
);
    logic [STATE_W-1:0]   state_in;
    logic                 load;
    logic                 inject_en;
    logic [1:0]           inject_sel;
    logic [STATE_W-1:0]   inject_mask;
    logic [STATE_W-1:0]   state_out;
    logic                 err_single;
    logic                 err_multi;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 fail;

    modport master (
        output state_in, load, inject_en, inject_sel, inject_mask,
        input  state_out, err_single, err_multi, err_cnt, fail
    );

    modport slave (
        input  state_in, load, inject_en, inject_sel, inject_mask,
        output state_out, err_single, err_multi, err_cnt, fail
    );
endinterface

// File: rtl/tmr_state_scrubber.sv
// Triple-redundant mode-FSM state register with majority vote, scrub, upset counter and sticky fail.
// SEU_INJECT_EN enables the test-only injection XOR; undefined, the injection inputs are ignored.
module tmr_state_scrubber #(
    parameter int STATE_W     = 3,
    parameter int ERR_CNT_W   = 8,
    parameter int FAIL_THRESH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    tmr_state_scrubber_if.slave  bus
);
    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        SCRUB    = 2'd1,
        DEGRADED = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [STATE_W-1:0]   r_c0, r_c1, r_c2;
    logic [STATE_W-1:0]   w_c0_upd, w_c1_upd, w_c2_upd;
    logic [STATE_W-1:0]   w_c0_nxt, w_c1_nxt, w_c2_nxt;
    logic [STATE_W-1:0]   w_vote;
    logic                 w_clean, w_multi;
    logic                 r_err_single, r_err_multi;
    logic                 w_err_single_nxt, w_err_multi_nxt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [3:0]           r_consec, w_consec_nxt, w_consec_inc;
    logic                 r_fail, w_fail_nxt;

    assign w_vote  = (r_c0 & r_c1) | (r_c1 & r_c2) | (r_c0 & r_c2);
    assign w_clean = (r_c0 == r_c1) && (r_c1 == r_c2);
    assign w_multi = (r_c0 != r_c1) && (r_c1 != r_c2) && (r_c0 != r_c2);
    assign w_consec_inc = (r_consec == 4'hF) ? r_consec : r_consec + 4'd1;

    // Rewriting every copy from the vote equals repairing only the odd one.
    always_comb begin
        w_c0_upd = r_c0;
        w_c1_upd = r_c1;
        w_c2_upd = r_c2;
        if (bus.load) begin
            w_c0_upd = bus.state_in;
            w_c1_upd = bus.state_in;
            w_c2_upd = bus.state_in;
        end else if (!w_clean) begin
            w_c0_upd = w_vote;
            w_c1_upd = w_vote;
            w_c2_upd = w_vote;
        end
    end

`ifdef SEU_INJECT_EN
    assign w_c0_nxt = w_c0_upd ^ ((bus.inject_en && bus.inject_sel == 2'd0) ? bus.inject_mask : '0);
    assign w_c1_nxt = w_c1_upd ^ ((bus.inject_en && bus.inject_sel == 2'd1) ? bus.inject_mask : '0);
    assign w_c2_nxt = w_c2_upd ^ ((bus.inject_en && bus.inject_sel == 2'd2) ? bus.inject_mask : '0);
`else
    logic w_unused_inject;
    assign w_unused_inject = ^{bus.inject_en, bus.inject_sel, bus.inject_mask};
    assign w_c0_nxt = w_c0_upd;
    assign w_c1_nxt = w_c1_upd;
    assign w_c2_nxt = w_c2_upd;
`endif

    // A single upset does not break the consecutive count, so a stuck bit
    // (alternating single/verify-fail) still accumulates towards fail.
    always_comb begin
        w_state_nxt      = r_state;
        w_err_single_nxt = 1'b0;
        w_err_multi_nxt  = 1'b0;
        w_consec_nxt     = r_consec;
        w_fail_nxt       = r_fail;
        case (r_state)
            NORMAL, DEGRADED: begin
                if (w_clean) begin
                    w_consec_nxt = '0;
                end else if (!bus.load) begin
                    if (w_multi) begin
                        w_err_multi_nxt = 1'b1;
                        w_consec_nxt    = w_consec_inc;
                    end else begin
                        w_err_single_nxt = 1'b1;
                        if (r_state == NORMAL) w_state_nxt = SCRUB;
                    end
                end
            end
            SCRUB: begin
                w_state_nxt = NORMAL;
                if (w_clean || bus.load) begin
                    w_consec_nxt = '0;
                end else begin
                    w_err_multi_nxt = 1'b1;
                    w_consec_nxt    = w_consec_inc;
                end
            end
            default: w_state_nxt = NORMAL;
        endcase
        if (r_fail || (w_consec_nxt >= 4'(FAIL_THRESH))) begin
            w_fail_nxt  = 1'b1;
            w_state_nxt = DEGRADED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= NORMAL;
            r_c0         <= '0;
            r_c1         <= '0;
            r_c2         <= '0;
            r_err_single <= 1'b0;
            r_err_multi  <= 1'b0;
            r_err_cnt    <= '0;
            r_consec     <= '0;
            r_fail       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_c0         <= w_c0_nxt;
            r_c1         <= w_c1_nxt;
            r_c2         <= w_c2_nxt;
            r_err_single <= w_err_single_nxt;
            r_err_multi  <= w_err_multi_nxt;
            r_consec     <= w_consec_nxt;
            r_fail       <= w_fail_nxt;
            if ((w_err_single_nxt || w_err_multi_nxt) && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign bus.state_out  = w_vote;
    assign bus.err_single = r_err_single;
    assign bus.err_multi  = r_err_multi;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.fail       = r_fail;
endmodule
